// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window buffer.
package conv_pkg;

  localparam int PIXEL_W = 4;
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FLUSH,
    ST_DONE
  } conv_state_e;

  // Zero-padding margin for an odd window of side n ("same" convolution).
  function automatic int pad(input int n);
    return (n - 1) / 2;
  endfunction

  // Windows emitted per frame: one per centre pixel.
  function automatic int window_count(input int image_width);
    return image_width * image_width;
  endfunction

  // Pixels held in the delay line: enough to reach the top-left tap.
  function automatic int line_depth(input int n, input int image_width);
    return (n - 1) * image_width + n;
  endfunction

endpackage

// File: rtl/conv_line_shift.sv
// Fixed-depth pixel delay line; tap 0 is the newest pixel.
module conv_line_shift #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic                        shift_en,
  input  logic [WIDTH-1:0]            shift_data,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      taps <= '0;
    end else if (shift_en) begin
      taps[0] <= shift_data;
      for (int t = 1; t < DEPTH; t++) taps[t] <= taps[t-1];
    end
  end

endmodule

// File: rtl/convolution_buffer.sv
// Streams a raster image and emits one zero-padded NxN window per pixel.
// Optional simulation checks are compiled in with CONV_BUFFER_ASSERT_EN.
module convolution_buffer
  import conv_pkg::*;
#(
  parameter int N          = 3,
  parameter int BitSize    = 4,
  parameter int ImageWidth = 4
) (
  input  logic                                 clk,
  input  logic                                 res_n,
  input  logic                                 in_valid,
  input  logic [BitSize-1:0]                   in_data,
  output logic                                 out_ready,
  output logic                                 out_valid,
  output logic [N-1:0][N-1:0][BitSize-1:0]     out_data,
  output logic                                 out_done
);

  localparam int P     = pad(N);
  localparam int Lead  = P * ImageWidth + P;
  localparam int Depth = line_depth(N, ImageWidth);
  localparam int Frame = window_count(ImageWidth);
  localparam int CntW  = $clog2(Frame + 1);
  localparam int PosW  = $clog2(ImageWidth + 1);

  conv_state_e                      state, state_nxt;
  logic [CntW-1:0]                  in_cnt;
  logic [PosW-1:0]                  cen_row, cen_col;
  logic                             shift_en, accept, produce, last_win;
  logic [BitSize-1:0]               shift_data;
  logic [Depth-1:0][BitSize-1:0]    taps, next_taps;
  logic [N-1:0][N-1:0][BitSize-1:0] win;

  conv_line_shift #(
    .DEPTH(Depth),
    .WIDTH(BitSize)
  ) u_line (
    .clk       (clk),
    .res_n     (res_n),
    .shift_en  (shift_en),
    .shift_data(shift_data),
    .taps      (taps)
  );

  function automatic logic in_image(input int v);
    return (v >= 0) && (v < ImageWidth);
  endfunction

  assign last_win = (cen_row == PosW'(ImageWidth - 1)) && (cen_col == PosW'(ImageWidth - 1));

  // Flush shifts zeros so the trailing centres line up with the fixed taps.
  always_comb begin : fsm_next
    state_nxt  = state;
    out_ready  = 1'b0;
    shift_en   = 1'b0;
    shift_data = '0;
    accept     = 1'b0;
    produce    = 1'b0;
    unique case (state)
      ST_FILL: begin
        out_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          shift_en   = 1'b1;
          shift_data = in_data;
          produce    = (in_cnt >= CntW'(Lead));
          if (in_cnt == CntW'(Frame - 1)) state_nxt = (Lead == 0) ? ST_DONE : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        shift_en = 1'b1;
        produce  = 1'b1;
        if (last_win) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // Window is taken from the post-shift line so it registers on the accepting edge.
  always_comb begin : window_mux
    next_taps[0] = shift_data;
    for (int t = 1; t < Depth; t++) next_taps[t] = taps[t-1];
    win = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (in_image(int'(cen_row) + r - P) && in_image(int'(cen_col) + c - P))
          win[r][c] = next_taps[(N - 1 - r) * ImageWidth + (N - 1 - c)];
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_FILL;
      in_cnt    <= '0;
      cen_row   <= '0;
      cen_col   <= '0;
      out_valid <= 1'b0;
      out_done  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= produce;
      out_done  <= produce && last_win;
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (produce) begin
        out_data <= win;
        if (last_win) begin
          cen_row <= '0;
          cen_col <= '0;
          in_cnt  <= '0;
        end else if (cen_col == PosW'(ImageWidth - 1)) begin
          cen_col <= '0;
          cen_row <= cen_row + 1'b1;
        end else begin
          cen_col <= cen_col + 1'b1;
        end
      end
    end
  end

`ifdef CONV_BUFFER_ASSERT_EN
  logic [CntW:0] vld_cnt;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) vld_cnt <= '0;
    else if (out_valid && out_done) vld_cnt <= '0;
    else if (out_valid) vld_cnt <= vld_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      assert (N % 2 == 1) else $error("window size must be odd");
      assert (N <= ImageWidth) else $error("window larger than image");
      assert (!(in_valid && out_ready) || !$isunknown(in_data)) else $error("unknown pixel accepted");
      assert (vld_cnt < (CntW + 1)'(Frame)) else $error("too many windows in frame");
      assert (!out_done || out_valid) else $error("done without valid");
    end
  end
`else
  // Checks excluded from this build.
`endif

endmodule

// File: tb/tb_convolution_buffer.sv
// Randomized bench for convolution_buffer against a window-by-window image model.
module tb_convolution_buffer;

  localparam int N    = 3;
  localparam int BW   = 4;
  localparam int IW   = 4;
  localparam int PADW = (N - 1) / 2;
  localparam int LEAD = PADW * IW + PADW;
  localparam int NPIX = IW * IW;

  typedef logic [N-1:0][N-1:0][BW-1:0] win_t;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          out_ready, out_valid, out_done;
  win_t          out_data;

  int   errors = 0;
  int   checks = 0;
  int   img[NPIX];
  win_t obs[NPIX];
  win_t last_data;
  win_t win0, win5, win15;

  localparam int DIR_IMG[NPIX] = '{7, 2, 2, 15, 8, 8, 15, 7, 15, 2, 8, 8, 15, 8, 8, 8};

  always #5 clk = ~clk;

  convolution_buffer #(
    .N(N),
    .BitSize(BW),
    .ImageWidth(IW)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_done (out_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window around centre k read straight from the image, zero outside it.
  function automatic win_t ref_window(input int k);
    win_t w;
    int rr, cc;
    w = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        rr = k / IW + r - PADW;
        cc = k % IW + c - PADW;
        if (rr >= 0 && rr < IW && cc >= 0 && cc < IW) w[r][c] = BW'(img[rr * IW + cc]);
      end
    end
    return w;
  endfunction

  function automatic win_t pack9(input int a[9]);
    win_t w;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) w[r][c] = BW'(a[r * N + c]);
    return w;
  endfunction

  task automatic run_frame(input int gap_pct, input string name);
    int j, w, cyc;
    bit iv, ev;
    j = 0; w = 0; cyc = 0;
    while (w < NPIX && cyc < 400) begin
      iv = (j < NPIX) && ($urandom_range(0, 99) >= gap_pct);
      in_valid = iv;
      in_data  = iv ? BW'(img[j]) : BW'($urandom);
      check({name, ".ready"}, 64'(out_ready), 64'(j < NPIX));
      @(posedge clk); #1;
      cyc++;
      if (iv) j++;
      ev = iv ? (j - 1 >= LEAD) : (j == NPIX);
      check({name, ".valid"}, 64'(out_valid), 64'(ev));
      check({name, ".done"}, 64'(out_done), 64'(ev && w == NPIX - 1));
      if (ev) begin
        check($sformatf("%s.win%0d", name, w), 64'(out_data), 64'(ref_window(w)));
        obs[w] = out_data;
        last_data = out_data;
        w++;
      end else begin
        check({name, ".hold"}, 64'(out_data), 64'(last_data));
      end
    end
    in_valid = 1'b0;
    if (w < NPIX) begin
      check({name, ".timeout_windows"}, 64'(w), 64'(NPIX));
    end else begin
      check({name, ".ready_in_done"}, 64'(out_ready), 64'd0);
      @(posedge clk); #1;
      check({name, ".ready_after"}, 64'(out_ready), 64'd1);
      check({name, ".valid_after"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic check_directed(input string name);
    check({name, ".c0"}, 64'(obs[0]), 64'(win0));
    check({name, ".c5"}, 64'(obs[5]), 64'(win5));
    check({name, ".c15"}, 64'(obs[15]), 64'(win15));
  endtask

  initial begin
    win0  = pack9('{0, 0, 0, 0, 7, 2, 0, 8, 8});
    win5  = pack9('{7, 2, 2, 8, 8, 15, 15, 2, 8});
    win15 = pack9('{8, 8, 0, 8, 8, 0, 0, 0, 0});

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 64'(out_ready), 64'd1);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.done", 64'(out_done), 64'd0);
    check("rst.data", 64'(out_data), 64'd0);
    res_n = 1'b1;
    last_data = '0;

    img = DIR_IMG;
    run_frame(0, "dir");
    check_directed("dir");

    run_frame(40, "stall");
    check_directed("stall");

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, (1 << BW) - 1));
      run_frame(30, $sformatf("rnd%0d", f));
    end

    img = DIR_IMG;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = BW'(img[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid.valid_before", 64'(out_valid), 64'd1);
    res_n = 1'b0;
    #2;
    check("mid.valid", 64'(out_valid), 64'd0);
    check("mid.ready", 64'(out_ready), 64'd1);
    check("mid.data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    res_n = 1'b1;
    last_data = '0;
    run_frame(0, "post_rst");
    check_directed("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/convolution_buffer.md
CONVOLUTION_BUFFER -- requirements
Module: convolution_buffer

Interface
REQ-001 SHALL have parameter N, default 3: square window size, odd, 1 <= N <= ImageWidth.
REQ-002 SHALL have parameter BitSize, default 4: pixel width in bits (unsigned).
REQ-003 SHALL have parameter ImageWidth, default 4: square image side length in pixels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port res_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data holds a pixel.
REQ-007 SHALL have port in_data, input, BitSize bits: the next raster-order pixel (row 0 first, column 0 first).
REQ-008 SHALL have port out_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a window.
REQ-010 SHALL have port out_data, output, [N][N][BitSize] bits: window as out_data[row][col], with [0][0] top-left.
REQ-011 SHALL have port out_done, output, 1 bit: one-cycle pulse with the last window of a frame.

Function
REQ-012 SHALL accept a pixel exactly on rising edges where in_valid=1 and out_ready=1; otherwise in_data is ignored.
REQ-013 SHALL emit exactly ImageWidth*ImageWidth windows per frame, one per centre pixel, in raster order of centres.
REQ-014 SHALL use zero padding ("same" convolution), P=(N-1)/2: window positions outside the image read 0.
REQ-015 SHALL register the window for centre k (out_valid=1 the cycle after) on the edge accepting pixel k+P*ImageWidth+P, for centres k <= ImageWidth*ImageWidth-1-(P*ImageWidth+P).
REQ-016 SHALL drive out_ready=0 from the edge accepting the last pixel of a frame until the remaining P*ImageWidth+P windows are flushed, one per cycle on consecutive edges.
REQ-017 SHALL assert out_done for the single cycle in which the centre-(ImageWidth*ImageWidth-1) window is valid; out_ready SHALL return to 1 on the following edge, and the next frame starts from pixel 0.
REQ-018 SHALL hold out_valid=0 in any cycle without a newly produced window; in_valid=0 stalls production outside the flush phase.
REQ-019 SHALL hold out_data stable while out_valid=0; there is no downstream backpressure.
REQ-020 SHALL store only (N-1)*ImageWidth+N pixels in a shift register with fixed taps, masking padded taps from the row and column counters of the centre pixel.

Reset
REQ-021 SHALL, while res_n=0, force out_valid=0, out_done=0, out_ready=1, out_data all zero, storage zero, and counters 0.
REQ-022 SHALL discard a partial frame on reset mid-frame; the first pixel accepted after reset is pixel 0 of a new frame.

Configuration
REQ-023 SHALL, when CONV_BUFFER_ASSERT_EN is defined, include simulation assertions: N odd, N <= ImageWidth, in_data not X on accept, at most ImageWidth*ImageWidth out_valid cycles per frame, and out_done only with out_valid.
REQ-024 SHALL, when CONV_BUFFER_ASSERT_EN is undefined, contain no assertion logic, with identical functional behaviour.

Structure
REQ-025 SHALL place in a shared package conv_pkg the pixel typedef parameterised helpers, the padding function P(N), and the window-count constant function.
REQ-026 SHALL implement the delay line as sub-module conv_line_shift (depth, width parameters; shift-enable; parallel tap output); counters and masking stay in convolution_buffer.

Verification
REQ-027 Reset check: hold res_n=0 -> out_ready=1, out_valid=0, out_done=0, out_data=0.
REQ-028 Test image, N=3, ImageWidth=4, rows {7,2,2,15},{8,8,15,7},{15,2,8,8},{15,8,8,8}, streamed with in_valid=1 -> after the 6th accept, out_valid=1 with window {0,0,0},{0,7,2},{0,8,8}.
REQ-029 Same stream -> after the 11th accept, window {7,2,2},{8,8,15},{15,2,8}.
REQ-030 Same stream -> after the 16th accept, out_ready=0 for 5 flush windows; the last window is {8,8,0},{8,8,0},{0,0,0} with out_done=1; then out_ready=1.
REQ-031 Stall check: in_valid gaps mid-frame -> identical window sequence, with no out_valid during gaps.
REQ-032 Mid-frame reset after 7 accepts, then a full frame -> exactly 16 windows, matching REQ-028 to REQ-030.
